pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline stage register with valid/ready flow control.
//  Carries one payload per transfer: result data, destination register address and control bits.
//  Supports stall (backpressure), flush (bubble insertion) and an optional 2-entry skid buffer that registers in_ready_o.
//  Placed between any two CPU pipeline stages (IF/ID ... MEM/WB); this is the generic stage register for the next core.
// PARAMETERS
//  DATA_W  32  width of in_data_i/out_data_o (result or load data)
//  ADDR_W  5   width of destination register address
//  CTRL_W  2   width of control bundle (e.g. {RegWrite, MemToReg}); bit 0 = RegWrite by convention
//  SKID    1   1: 2-entry skid buffer, registered in_ready_o; 0: single entry, combinational in_ready_o
// PORTS
//  clk_i         in   1       clock, all state on rising edge
//  rst_n_i       in   1       asynchronous reset, active low
//  flush_i       in   1       synchronous flush: discard all held entries
//  in_valid_i    in   1       upstream payload valid
//  in_ready_o    out  1       stage can accept; transfer in_fire = in_valid_i & in_ready_o
//  in_data_i     in   DATA_W  upstream data
//  in_rdaddr_i   in   ADDR_W  upstream destination register
//  in_ctrl_i     in   CTRL_W  upstream control bits
//  out_valid_o   out  1       payload valid to downstream
//  out_ready_i   in   1       downstream accepts; out_fire = out_valid_o & out_ready_i
//  out_data_o    out  DATA_W  held data
//  out_rdaddr_o  out  ADDR_W  held destination register
//  out_ctrl_o    out  CTRL_W  held control bits, forced 0 while out_valid_o=0
//  occupancy_o   out  2       entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
//  Reset (rst_n_i=0, async): state EMPTY, out_valid_o=0, out_data_o/out_rdaddr_o/out_ctrl_o=0,
//   skid entry=0, occupancy_o=0; in_ready_o=1 once reset deasserts (SKID=1), =1 combinationally (SKID=0).
//  Latency 1 cycle: payload taken on in_fire appears with out_valid_o=1 next cycle. Throughput 1/cycle.
//  Payload held stable while out_valid_o=1 & out_ready_i=0; never altered except by out_fire or flush.
//  SKID=1 states (main entry M, skid entry S); in_ready_o = (state != FULL), registered:
//   EMPTY: in_fire -> BUSY, M<=in.
//   BUSY : in_fire&!out_fire -> FULL, S<=in; !in_fire&out_fire -> EMPTY; both -> BUSY, M<=in; else hold.
//   FULL : out_fire -> BUSY, M<=S; else hold. in_ready_o=0, no input accepted.
//   Order preserved: S always younger than M.
//  SKID=0: single entry M; in_ready_o = !out_valid_o | out_ready_i; EMPTY/BUSY only;
//   in_fire loads M; out_fire without in_fire -> EMPTY.
//  Flush: next state EMPTY, occupancy 0, out_valid_o=0; overrides same-cycle in_fire (input counted
//   as accepted and dropped) and out_fire (downstream may have consumed; no replay). Data regs may keep
//   stale values, but out_ctrl_o reads 0 because out_valid_o=0.
//  Bubble gating: out_ctrl_o = out_valid_o ? M.ctrl : 0, so RegWrite never asserts for a bubble.
//  occupancy_o: EMPTY=0, BUSY=1, FULL=2; always equals registered state.
//  Reset asserted mid-transfer: all entries lost immediately; no partial outputs.
//  Widths: payload = {ctrl, rdaddr, data}, CTRL_W+ADDR_W+DATA_W bits, no arithmetic.
//  in_valid_i low with in_ready_o high: nothing captured, payload inputs ignored (X-tolerant).
// STRUCTURE
//  Shared package pipe_pkg: state encoding localparams ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2,
//   and default widths (DATA_W/ADDR_W/CTRL_W) shared by all stage instances.
//  One sub-module: pipe_payload_reg (enable-loaded, async-reset payload register), instantiated for M
//   and, under generate SKID=1, for S. FSM and muxing live in pipe_stage_skid.
// TESTING
//  1 Reset: rst_n_i low 3 cycles with in_valid_i=1 -> out_valid_o=0, out_ctrl_o=0, occupancy_o=0; in_ready_o=1 after release.
//  2 Streaming: out_ready_i=1, send data 0x00000001..0x00000008 back-to-back -> same order, 1-cycle latency, no gaps.
//  3 Stall (SKID=1): out_ready_i=0, send A=0xAAAA0000, B=0xBBBB0000 -> occupancy 2, in_ready_o=0 next cycle;
//    C held upstream; release -> outputs A,B,C in order, nothing dropped or duplicated.
//  4 Flush in FULL with in_fire same cycle -> next cycle occupancy 0, out_valid_o=0, out_ctrl_o=0; flushed input never emerges.
//  5 Bubble gating: in_ctrl_i=2'b11 then idle -> out_ctrl_o=2'b11 one cycle, then 2'b00 while out_valid_o=0.
//  6 SKID=0 build: out_ready_i toggles 1,0,1,0 with continuous in_valid_i -> in_ready_o tracks out_ready_i same cycle;
//    ordered, lossless output.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register: state encoding and default widths.
package pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int CTRL_W_DEF = 2;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-loaded payload register with asynchronous active-low reset to zero.
module pipe_payload_reg #(
   parameter int W = 39
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_r;

   // Capture the payload only when loaded; otherwise hold.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         q_r <= {W{1'b0}};
      end else if (en_i) begin
         q_r <= d_i;
      end else begin
         q_r <= q_r;
      end
   end

   assign q_o = q_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with flush and an optional 2-entry skid buffer.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int SKID   = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [ADDR_W-1:0] in_rdaddr_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [ADDR_W-1:0] out_rdaddr_o,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [1:0]        occupancy_o
);

   localparam int PAY_W = CTRL_W + ADDR_W + DATA_W;

   logic [PAY_W-1:0] in_pay_s;
   logic [PAY_W-1:0] m_d_s;
   logic [PAY_W-1:0] m_q_s;
   logic [PAY_W-1:0] s_q_s;
   logic             m_en_s;
   logic             s_en_s;
   logic             in_fire_s;
   logic             out_fire_s;
   logic             in_ready_s;
   logic             out_valid_r;
   logic             in_ready_r;
   state_e           state_r;
   state_e           state_nxt_s;

   assign in_pay_s   = {in_ctrl_i, in_rdaddr_i, in_data_i};
   // Without a skid entry the stage can only accept when its single entry drains this cycle.
   assign in_ready_s = (SKID != 0) ? in_ready_r : (!out_valid_r | out_ready_i);
   assign in_fire_s  = in_valid_i & in_ready_s;
   assign out_fire_s = out_valid_r & out_ready_i;

   // Next-state and entry-load decode; flush discards everything, including a same-cycle input.
   always_comb begin
      state_nxt_s = state_r;
      m_en_s      = 1'b0;
      s_en_s      = 1'b0;
      m_d_s       = in_pay_s;
      if (flush_i) begin
         state_nxt_s = ST_EMPTY;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  state_nxt_s = ST_BUSY;
                  m_en_s      = 1'b1;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_BUSY: begin
               if (in_fire_s && out_fire_s) begin
                  state_nxt_s = ST_BUSY;
                  m_en_s      = 1'b1;
               end else if (in_fire_s) begin
                  if (SKID != 0) begin
                     state_nxt_s = ST_FULL;
                     s_en_s      = 1'b1;
                  end else begin
                     state_nxt_s = ST_BUSY;
                     m_en_s      = 1'b1;
                  end
               end else if (out_fire_s) begin
                  state_nxt_s = ST_EMPTY;
               end else begin
                  state_nxt_s = ST_BUSY;
               end
            end
            ST_FULL: begin
               if (out_fire_s) begin
                  state_nxt_s = ST_BUSY;
                  m_en_s      = 1'b1;
                  m_d_s       = s_q_s;
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end
            default: begin
               state_nxt_s = ST_EMPTY;
            end
         endcase
      end
   end

   // State register plus registered valid/ready flags derived from the next state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r     <= ST_EMPTY;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         out_valid_r <= (state_nxt_s != ST_EMPTY);
         in_ready_r  <= (state_nxt_s != ST_FULL);
      end
   end

   pipe_payload_reg #(.W(PAY_W)) u_main (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (m_en_s),
      .d_i     (m_d_s),
      .q_o     (m_q_s)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_payload_reg #(.W(PAY_W)) u_skid (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .en_i    (s_en_s),
            .d_i     (in_pay_s),
            .q_o     (s_q_s)
         );
      end else begin : g_no_skid
         assign s_q_s = {PAY_W{1'b0}};
      end
   endgenerate

   assign in_ready_o   = in_ready_s;
   assign out_valid_o  = out_valid_r;
   assign out_data_o   = m_q_s[DATA_W-1:0];
   assign out_rdaddr_o = m_q_s[DATA_W +: ADDR_W];
   // A bubble must never present RegWrite downstream.
   assign out_ctrl_o   = out_valid_r ? m_q_s[PAY_W-1 -: CTRL_W] : {CTRL_W{1'b0}};
   assign occupancy_o  = state_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance, each with a FIFO reference model.
module tb_pipe_stage_skid;

   localparam int PW = 39;

   logic clk;
   logic rst_n;
   logic flush;

   logic        v1, rdy1, ov1, or1;
   logic [31:0] d1, od1;
   logic [4:0]  a1, oa1;
   logic [1:0]  c1, oc1, occ1;

   logic        v0, rdy0, ov0, or0;
   logic [31:0] d0, od0;
   logic [4:0]  a0, oa0;
   logic [1:0]  c0, oc0, occ0;

   logic [PW-1:0] q1[$];
   logic [PW-1:0] q0[$];

   int n_checks = 0;
   int n_fail   = 0;

   pipe_stage_skid #(.SKID(1)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
      .in_valid_i(v1), .in_ready_o(rdy1), .in_data_i(d1), .in_rdaddr_i(a1), .in_ctrl_i(c1),
      .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1), .out_rdaddr_o(oa1),
      .out_ctrl_o(oc1), .occupancy_o(occ1)
   );

   pipe_stage_skid #(.SKID(0)) dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
      .in_valid_i(v0), .in_ready_o(rdy0), .in_data_i(d0), .in_rdaddr_i(a0), .in_ctrl_i(c0),
      .out_valid_o(ov0), .out_ready_i(or0), .out_data_o(od0), .out_rdaddr_o(oa0),
      .out_ctrl_o(oc0), .occupancy_o(occ0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor for the SKID=1 instance: compare against the model, then advance the model.
   always @(negedge clk) begin
      logic ev, er;
      if (!rst_n) begin
         q1.delete();
         check("rst_valid1", {63'd0, ov1}, 64'd0);
         check("rst_occ1", {62'd0, occ1}, 64'd0);
         check("rst_ctrl1", {62'd0, oc1}, 64'd0);
         check("rst_data1", {32'd0, od1}, 64'd0);
      end else begin
         ev = (q1.size() != 0);
         er = (q1.size() < 2);
         check("occ1", {62'd0, occ1}, 64'(q1.size()));
         check("valid1", {63'd0, ov1}, {63'd0, ev});
         check("ready1", {63'd0, rdy1}, {63'd0, er});
         if (ev) check("payload1", {25'd0, oc1, oa1, od1}, {25'd0, q1[0]});
         else    check("bubble_ctrl1", {62'd0, oc1}, 64'd0);
         if (flush) q1.delete();
         else begin
            if (ev && or1) void'(q1.pop_front());
            if (v1 && er) q1.push_back({c1, a1, d1});
         end
      end
   end

   // Monitor for the SKID=0 instance; ready follows downstream readiness in the same cycle.
   always @(negedge clk) begin
      logic ev, er;
      if (!rst_n) begin
         q0.delete();
         check("rst_valid0", {63'd0, ov0}, 64'd0);
         check("rst_occ0", {62'd0, occ0}, 64'd0);
         check("rst_ctrl0", {62'd0, oc0}, 64'd0);
      end else begin
         ev = (q0.size() != 0);
         er = !ev || or0;
         check("occ0", {62'd0, occ0}, 64'(q0.size()));
         check("valid0", {63'd0, ov0}, {63'd0, ev});
         check("ready0", {63'd0, rdy0}, {63'd0, er});
         if (ev) check("payload0", {25'd0, oc0, oa0, od0}, {25'd0, q0[0]});
         else    check("bubble_ctrl0", {62'd0, oc0}, 64'd0);
         if (flush) q0.delete();
         else begin
            if (ev && or0) void'(q0.pop_front());
            if (v0 && er) q0.push_back({c0, a0, d0});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one payload on the SKID=1 input and hold it until it is accepted.
   task automatic send1(input logic [31:0] d, input logic [4:0] a, input logic [1:0] c);
      logic fired;
      int   n;
      v1 = 1'b1; d1 = d; a1 = a; c1 = c;
      fired = 1'b0;
      n = 0;
      while (!fired && n < 50) begin
         @(negedge clk);
         fired = rdy1;
         step();
         n++;
      end
      if (!fired) begin
         n_checks++;
         n_fail++;
         $display("FAIL send1_timeout: data %0h not accepted within 50 cycles", d);
      end
      v1 = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   initial begin
      logic        fired;
      logic [31:0] cnt;
      rst_n = 1'b0; flush = 1'b0;
      v1 = 1'b1; d1 = 32'hDEAD_BEEF; a1 = 5'd3; c1 = 2'b11; or1 = 1'b1;
      v0 = 1'b1; d0 = 32'hDEAD_BEEF; a0 = 5'd3; c0 = 2'b11; or0 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      v1 = 1'b0; v0 = 1'b0;
      step();

      // Streaming back-to-back
      for (int i = 1; i <= 8; i++) send1(32'(i), 5'(i), 2'b01);
      repeat (2) step();

      // Stall fills both entries, third payload waits upstream
      or1 = 1'b0;
      send1(32'hAAAA_0000, 5'd10, 2'b01);
      send1(32'hBBBB_0000, 5'd11, 2'b10);
      v1 = 1'b1; d1 = 32'hCCCC_0000; a1 = 5'd12; c1 = 2'b11;
      repeat (3) step();
      or1 = 1'b1;
      send1(32'hCCCC_0000, 5'd12, 2'b11);
      repeat (3) step();

      // Flush while FULL with a valid input waiting, then flush in BUSY with an input accepted
      or1 = 1'b0;
      send1(32'h1111_0000, 5'd1, 2'b01);
      send1(32'h2222_0000, 5'd2, 2'b01);
      v1 = 1'b1; d1 = 32'h3333_0000; a1 = 5'd3; c1 = 2'b11;
      do_flush();
      v1 = 1'b0;
      send1(32'h4444_0000, 5'd4, 2'b01);
      v1 = 1'b1; d1 = 32'h5555_0000; a1 = 5'd5; c1 = 2'b11;
      do_flush();
      v1 = 1'b0;
      or1 = 1'b1;
      step();
      send1(32'h6666_0000, 5'd6, 2'b01);
      repeat (2) step();

      // Bubble gating of control bits
      send1(32'h7777_0000, 5'd7, 2'b11);
      repeat (3) step();

      // Mid-transfer asynchronous reset
      or1 = 1'b0;
      send1(32'h8888_0000, 5'd8, 2'b01);
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      or1 = 1'b1;
      step();

      // Randomised traffic on the SKID=1 stage
      for (int i = 0; i < 400; i++) begin
         v1 = 1'($urandom_range(0, 1));
         d1 = $urandom;
         a1 = 5'($urandom_range(0, 31));
         c1 = 2'($urandom_range(0, 3));
         or1 = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 24) == 0);
         step();
      end
      v1 = 1'b0; flush = 1'b0; or1 = 1'b1;
      repeat (4) step();

      // SKID=0: downstream ready toggles with continuous upstream valid
      cnt = 32'd1;
      for (int i = 0; i < 8; i++) begin
         or0 = (i % 2 == 0);
         v0 = 1'b1; d0 = cnt; a0 = 5'(cnt); c0 = 2'b01;
         @(negedge clk);
         fired = rdy0;
         step();
         if (fired) cnt = cnt + 32'd1;
      end
      v0 = 1'b0; or0 = 1'b1;
      repeat (3) step();

      // Randomised traffic on the SKID=0 stage
      for (int i = 0; i < 300; i++) begin
         v0 = 1'($urandom_range(0, 1));
         d0 = $urandom;
         a0 = 5'($urandom_range(0, 31));
         c0 = 2'($urandom_range(0, 3));
         or0 = 1'($urandom_range(0, 1));
         flush = ($urandom_range(0, 24) == 0);
         step();
      end
      v0 = 1'b0; flush = 1'b0; or0 = 1'b1;
      repeat (4) step();

      check("drain1", 64'(q1.size()), 64'd0);
      check("drain0", 64'(q0.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
